// File: rtl/vip_pkg.sv
// Shared constants for the video-pipe blocks: default pixel/dimension widths and FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vip_pkg;

  localparam int DWIDTH_DEF = 24;
  localparam int DIMW_DEF   = 11;

  // Frame reader FSM encoding; kept as plain constants so older blocks can share it.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/vip_skid_buf2.sv
// Two-entry FIFO that holds pixels read from the source until downstream takes them.
// Latency: a pushed word is visible at head_data the cycle after the push.
// Backpressure: head is held while pop is low; a push into a full buffer is dropped unless a pop frees a slot.
module vip_skid_buf2
  import vip_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head_data,
  output logic [1:0]        count
);

  logic [DWIDTH-1:0] mem0;
  logic [DWIDTH-1:0] mem1;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A pop on a full buffer frees the slot the write pointer is about to reuse.
  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && ((count != 2'd2) || do_pop);
  assign head_data = rd_ptr ? mem1 : mem0;

  // Storage, pointers and occupancy tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr) mem1 <= push_data;
        else        mem0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_frame_reader.sv
// Reads width*height*num_frame words from a non-show-ahead FIFO and emits them as framed pixels.
// Latency: first pixel valid 3 cycles after start (rdreq, FIFO data, buffer write); then 1 pixel/cycle.
// Backpressure: pix_ready low holds the head pixel and flags; reads stop once buffer plus in-flight reaches 2.
module fifo_frame_reader
  import vip_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DIMW   = DIMW_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DIMW-1:0]   width,
  input  logic [DIMW-1:0]   height,
  input  logic [DIMW-1:0]   num_frame,
  output logic              fifo_rdreq,
  input  logic [DWIDTH-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic [DWIDTH-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int TW = 3 * DIMW;

  logic [1:0]      state;
  logic [DIMW-1:0] w_q;
  logic [DIMW-1:0] h_q;
  logic [DIMW-1:0] n_q;
  logic [DIMW-1:0] x_q;
  logic [DIMW-1:0] y_q;
  logic [DIMW-1:0] f_q;
  logic [TW-1:0]   total_q;
  logic [TW-1:0]   req_cnt_q;
  logic            inflight_q;
  logic            done_q;

  logic [1:0]      occ;
  logic [2:0]      pending;
  logic            pop;
  logic            rd;
  logic            last_req;
  logic            last_xfer;
  logic            dims_zero;
  logic            launch;
  logic [DIMW-1:0] w_last;
  logic [DIMW-1:0] h_last;
  logic [DIMW-1:0] n_last;
  logic            at_eol;
  logic            at_eof;

  assign dims_zero = (width == '0) || (height == '0) || (num_frame == '0);
  assign launch    = (state == ST_IDLE) && start && !dims_zero;

  assign w_last = w_q - DIMW'(1);
  assign h_last = h_q - DIMW'(1);
  assign n_last = n_q - DIMW'(1);

  assign pix_valid = (occ != 2'd0);
  assign pop       = pix_valid && pix_ready;

  // Slots committed for the next cycle: stored words plus the word on its way, minus what leaves now.
  assign pending  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd       = (state == ST_RUN) && !fifo_empty && (req_cnt_q < total_q) && (pending < 3'd2);
  assign last_req = rd && (req_cnt_q == total_q - TW'(1));

  assign at_eol    = (x_q == w_last);
  assign at_eof    = at_eol && (y_q == h_last);
  assign last_xfer = pop && at_eof && (f_q == n_last);

  assign fifo_rdreq = rd;
  assign sof        = pix_valid && (x_q == '0) && (y_q == '0);
  assign eol        = pix_valid && at_eol;
  assign eof        = pix_valid && at_eof;
  assign busy       = (state != ST_IDLE);
  assign done       = done_q;

  vip_skid_buf2 #(
    .DWIDTH(DWIDTH)
  ) u_buf (
    .clock    (clock),
    .reset    (reset),
    .push     (inflight_q),
    .push_data(fifo_data),
    .pop      (pop),
    .head_data(pix_data),
    .count    (occ)
  );

  // Run control: latch geometry, count requests, track the word in flight, signal completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      n_q        <= '0;
      total_q    <= '0;
      req_cnt_q  <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rd;
      if (rd) begin
        req_cnt_q <= req_cnt_q + TW'(1);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (dims_zero) begin
              done_q <= 1'b1;
            end else begin
              w_q       <= width;
              h_q       <= height;
              n_q       <= num_frame;
              total_q   <= TW'(width) * TW'(height) * TW'(num_frame);
              req_cnt_q <= '0;
              state     <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (last_req) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (last_xfer) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Position of the pixel at the buffer head; moves only when that pixel is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      f_q <= '0;
    end else if (launch || last_xfer) begin
      x_q <= '0;
      y_q <= '0;
      f_q <= '0;
    end else if (pop) begin
      if (at_eol) begin
        x_q <= '0;
        if (y_q == h_last) begin
          y_q <= '0;
          f_q <= f_q + DIMW'(1);
        end else begin
          y_q <= y_q + DIMW'(1);
        end
      end else begin
        x_q <= x_q + DIMW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader with a FIFO model and a pixel scoreboard.
module tb_fifo_frame_reader;
  import vip_pkg::*;

  localparam int DW = 24;
  localparam int DM = 11;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DM-1:0] width = '0;
  logic [DM-1:0] height = '0;
  logic [DM-1:0] num_frame = '0;
  logic          fifo_rdreq;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic          sof;
  logic          eol;
  logic          eof;
  logic          busy;
  logic          done;

  fifo_frame_reader #(.DWIDTH(DW), .DIMW(DM)) dut (
    .clock(clock), .reset(reset), .start(start),
    .width(width), .height(height), .num_frame(num_frame),
    .fifo_rdreq(fifo_rdreq), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Non-show-ahead FIFO model: data appears the cycle after the read request.
  logic [DW-1:0] fmem [0:255];
  int   wr_idx = 0;
  int   rd_idx = 0;
  logic force_empty = 1'b0;
  assign fifo_empty = force_empty || (wr_idx == rd_idx);

  always @(posedge clock) begin
    if (!reset && fifo_rdreq) begin
      fifo_data <= fmem[rd_idx[7:0]];
      rd_idx    <= rd_idx + 1;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  int   xfer_cnt = 0;
  int   done_cnt = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  logic no_rd = 1'b0;

  int            occ_m = 0;
  logic          inf_m = 1'b0;
  logic          pend_done = 1'b0;
  logic          next_done;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic [2:0]    prev_f = '0;
  logic          pop_m;
  exp_t          e_m;

  // Monitor: occupancy model, scoreboard compare, hold and read-throttle checks, done timing.
  always @(negedge clock) begin
    if (reset) begin
      occ_m      = 0;
      inf_m      = 1'b0;
      pend_done  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      pop_m = pix_valid && pix_ready;
      check("valid_vs_occupancy", pix_valid, occ_m != 0);
      check("done_timing", done, pend_done);
      if (done) done_cnt++;
      if (fifo_rdreq) begin
        check("rdreq_while_empty", fifo_empty, 1'b0);
        check("rdreq_room", (occ_m + inf_m - pop_m) < 2, 1'b1);
      end
      if (no_rd) check("rdreq_zero_geom", fifo_rdreq, 1'b0);
      if (stall_prev) begin
        check("hold_data", pix_data, prev_d);
        check("hold_flags", {sof, eol, eof}, prev_f);
      end
      next_done = 1'b0;
      if (pop_m) begin
        check("sb_has_entry", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e_m = exp_q.pop_front();
          check("pix_data", pix_data, e_m.d);
          check("sof", sof, e_m.sof);
          check("eol", eol, e_m.eol);
          check("eof", eof, e_m.eof);
          next_done = e_m.last;
        end
        if (xfer_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfer_cnt++;
      end
      if (start && !busy && (width == '0 || height == '0 || num_frame == '0)) next_done = 1'b1;
      pend_done  = next_done;
      stall_prev = pix_valid && !pix_ready;
      prev_d     = pix_data;
      prev_f     = {sof, eol, eof};
      occ_m      = occ_m - int'(pop_m) + int'(inf_m);
      inf_m      = fifo_rdreq;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(int w, int h, int n);
    logic [DW-1:0] d;
    for (int f = 0; f < n; f++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          d = DW'($urandom);
          fmem[wr_idx[7:0]] = d;
          wr_idx++;
          exp_q.push_back({d, (x == 0 && y == 0), (x == w - 1), (x == w - 1 && y == h - 1),
                           (f == n - 1 && x == w - 1 && y == h - 1)});
        end
  endtask

  task automatic go(int w, int h, int n);
    width = DM'(w);
    height = DM'(h);
    num_frame = DM'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget && done_cnt < 1; i++) step();
    repeat (3) step();
    check("done_count", done_cnt, 1);
    check("sb_drained", exp_q.size(), 0);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic clear_counts();
    xfer_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_rdreq"}, fifo_rdreq, 1'b0);
    check({tag, "_valid"}, pix_valid, 1'b0);
    check({tag, "_flags"}, {sof, eol, eof}, 3'b000);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_data"}, pix_data, '0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    step();
    reset = 1'b0;
    step();

    // Streaming, 4x2x1, ready held high
    clear_counts();
    pix_ready = 1'b1;
    load(4, 2, 1);
    go(4, 2, 1);
    check("busy_in_run", busy, 1'b1);
    wait_done(60);
    check("stream_count", xfer_cnt, 8);
    check("stream_back_to_back", last_cyc - first_cyc, 7);

    // Backpressure, ready toggling 1,0,1,0
    clear_counts();
    load(4, 2, 1);
    go(4, 2, 1);
    for (int i = 0; i < 80 && done_cnt < 1; i++) begin
      pix_ready = (i % 2 == 0);
      step();
    end
    pix_ready = 1'b1;
    wait_done(20);
    check("bp_count", xfer_cnt, 8);

    // Underflow: FIFO reports empty for 5 cycles mid-line
    begin
      int snap;
      clear_counts();
      load(4, 2, 1);
      go(4, 2, 1);
      for (int i = 0; i < 50 && xfer_cnt < 2; i++) step();
      force_empty = 1'b1;
      repeat (3) step();
      snap = xfer_cnt;
      repeat (2) step();
      check("underflow_frozen", xfer_cnt, snap);
      check("underflow_drained", pix_valid, 1'b0);
      force_empty = 1'b0;
      wait_done(60);
      check("underflow_count", xfer_cnt, 8);
    end

    // Zero geometry with data waiting in the FIFO
    clear_counts();
    fmem[wr_idx[7:0]] = 24'h5a5a5a;
    wr_idx++;
    no_rd = 1'b1;
    go(4, 0, 1);
    check("zero_busy", busy, 1'b0);
    repeat (4) step();
    check("zero_done", done_cnt, 1);
    check("zero_no_pixels", xfer_cnt, 0);
    no_rd = 1'b0;
    wr_idx = rd_idx;

    // Multi-frame, 3x2x2
    clear_counts();
    load(3, 2, 2);
    go(3, 2, 2);
    wait_done(80);
    check("multi_count", xfer_cnt, 12);

    // Reset mid-run after 3 transfers, then a clean rerun
    clear_counts();
    load(4, 2, 1);
    go(4, 2, 1);
    for (int i = 0; i < 50 && xfer_cnt < 3; i++) step();
    check("pre_reset_xfers", xfer_cnt, 3);
    reset = 1'b1;
    exp_q.delete();
    wr_idx = rd_idx;
    @(negedge clock);
    check_all_zero("midreset");
    step();
    reset = 1'b0;
    repeat (4) step();
    check("midreset_no_done", done_cnt, 0);
    clear_counts();
    load(4, 2, 1);
    go(4, 2, 1);
    wait_done(60);
    check("rerun_count", xfer_cnt, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
